// File: rtl/led_bouncer_pkg.sv
// Shared types and width helpers for the bouncing-LED indicator.
package led_bouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  localparam logic [1:0] REG_MID   = 2'b00;
  localparam logic [1:0] REG_RIGHT = 2'b01;
  localparam logic [1:0] REG_LEFT  = 2'b10;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_bouncer_blink_gen.sv
// Square-wave phase generator: toggles every CLK_HZ/(2*RATE_HZ) enabled cycles.
module blink_gen
  import led_bouncer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int RATE_HZ = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase
);

  localparam int HALF = max_int(1, CLK_HZ / (2 * RATE_HZ));
  localparam int BW   = clog2_min1(HALF);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

  logic [BW-1:0] r_cnt;
  logic          r_phase;

  // Half-period counter and phase flip-flop; clr restarts the pattern lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (en) begin
      if (r_cnt == HALF_LAST) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + BW'(1);
      end
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/led_bouncer.sv
// Single lit LED walking along a bar, bouncing at both ends, with run/pause/stop control.
module led_bouncer
  import led_bouncer_pkg::*;
#(
  parameter int   N_LED      = 16,
  parameter int   CLK_HZ     = 100_000_000,
  parameter int   TICK_HZ    = 100,
  parameter int   T_UP       = 160,
  parameter int   T_DOWN     = 50,
  parameter int   LB         = 10,
  parameter int   RB         = 2,
  parameter int   START_POS  = 7,
  parameter logic DIR_INIT   = 1'b0,
  parameter int   BLINK_L_HZ = 5,
  parameter int   BLINK_R_HZ = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  output logic [N_LED-1:0]         led,
  output logic [$clog2(N_LED)-1:0] pos,
  output logic                     dir,
  output logic [1:0]               region,
  output logic                     running,
  output logic                     step
);

  localparam int PW    = $clog2(N_LED);
  localparam int PRESC = CLK_HZ / TICK_HZ;
  localparam int CW    = clog2_min1(PRESC);
  localparam int TW    = clog2_min1(max_int(T_UP, T_DOWN) + 1);

  localparam logic [CW-1:0] PRESC_LAST = CW'(PRESC - 1);
  localparam logic [TW-1:0] UP_LAST    = TW'(T_UP - 1);
  localparam logic [TW-1:0] DN_LAST    = TW'(T_DOWN - 1);
  localparam logic [PW-1:0] POS_TOP    = PW'(N_LED - 1);
  localparam logic [PW-1:0] POS_START  = PW'(START_POS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_presc;
  logic [TW-1:0]     r_tcnt;
  logic [PW-1:0]     r_pos;
  logic              r_dir;
  logic [N_LED-1:0]  r_led;
  logic              r_step;
  logic [N_LED-1:0]  w_led_nxt;
  logic [1:0]        w_region;
  logic              w_load;
  logic              w_cnt_en;
  logic              w_tick;
  logic              w_step_due;
  logic              w_phase_l;
  logic              w_phase_r;

  // start only acts from IDLE; stop overrides everything.
  assign w_load     = (r_state == ST_IDLE) && start && !stop;
  assign w_cnt_en   = (r_state == ST_RUN) && !stop;
  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_step_due = w_cnt_en && w_tick && (r_tcnt == (r_dir ? UP_LAST : DN_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (stop)       w_state_nxt = ST_IDLE;
        else if (start) w_state_nxt = ST_RUN;
        else            w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (stop)       w_state_nxt = ST_IDLE;
        else if (pause) w_state_nxt = ST_PAUSED;
        else            w_state_nxt = ST_RUN;
      end
      ST_PAUSED: begin
        if (stop)       w_state_nxt = ST_IDLE;
        else if (pause) w_state_nxt = ST_RUN;
        else            w_state_nxt = ST_PAUSED;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_tcnt  <= '0;
    end else if (w_load) begin
      r_presc <= '0;
      r_tcnt  <= '0;
    end else if (w_cnt_en) begin
      if (w_tick) begin
        r_presc <= '0;
        r_tcnt  <= w_step_due ? '0 : r_tcnt + TW'(1);
      end else begin
        r_presc <= r_presc + CW'(1);
      end
    end
  end

  // Bounce: an end position reverses direction and steps back inward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos  <= POS_START;
      r_dir  <= DIR_INIT;
      r_step <= 1'b0;
    end else begin
      r_step <= w_step_due;
      if (w_load) begin
        r_pos <= POS_START;
        r_dir <= DIR_INIT;
      end else if (w_step_due) begin
        if (r_dir) begin
          if (r_pos == POS_TOP) begin
            r_pos <= POS_TOP - PW'(1);
            r_dir <= 1'b0;
          end else begin
            r_pos <= r_pos + PW'(1);
          end
        end else begin
          if (r_pos == '0) begin
            r_pos <= PW'(1);
            r_dir <= 1'b1;
          end else begin
            r_pos <= r_pos - PW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    if (int'(r_pos) > LB)      w_region = REG_LEFT;
    else if (int'(r_pos) < RB) w_region = REG_RIGHT;
    else                       w_region = REG_MID;
  end

  blink_gen #(.CLK_HZ(CLK_HZ), .RATE_HZ(BLINK_L_HZ)) u_blink_l (
    .clk(clk), .rst(rst), .en(r_state == ST_RUN), .clr(w_load), .phase(w_phase_l)
  );

  blink_gen #(.CLK_HZ(CLK_HZ), .RATE_HZ(BLINK_R_HZ)) u_blink_r (
    .clk(clk), .rst(rst), .en(r_state == ST_RUN), .clr(w_load), .phase(w_phase_r)
  );

  always_comb begin
    w_led_nxt = '0;
    case (r_state)
      ST_RUN: begin
        case (w_region)
          REG_LEFT:  w_led_nxt[r_pos] = w_phase_l;
          REG_RIGHT: w_led_nxt[r_pos] = w_phase_r;
          default:   w_led_nxt[r_pos] = 1'b1;
        endcase
      end
      ST_PAUSED: w_led_nxt[r_pos] = 1'b1;
      default:   w_led_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign led     = r_led;
  assign pos     = r_pos;
  assign dir     = r_dir;
  assign region  = w_region;
  assign running = (r_state == ST_RUN);
  assign step    = r_step;

endmodule

// File: tb/tb_led_bouncer.sv
// Bench for led_bouncer: scripted scenarios plus random control, all checked against a cycle-count model.
module tb_led_bouncer;

  localparam int N = 8;
  localparam int T_UP = 4;
  localparam int T_DOWN = 2;
  localparam int LB = 5;
  localparam int RB = 1;
  localparam int START = 3;
  localparam int CLK_PER_TICK = 10;
  localparam int HALF_L = 10;
  localparam int HALF_R = 5;

  logic clk;
  logic rst, start, pause, stop;
  logic [N-1:0] led;
  logic [2:0] pos;
  logic dir, running, step;
  logic [1:0] region;

  led_bouncer #(
    .N_LED(N), .CLK_HZ(1000), .TICK_HZ(100), .T_UP(T_UP), .T_DOWN(T_DOWN),
    .LB(LB), .RB(RB), .START_POS(START), .DIR_INIT(1'b0),
    .BLINK_L_HZ(50), .BLINK_R_HZ(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .led(led), .pos(pos), .dir(dir), .region(region), .running(running), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: mode (0 idle, 1 run, 2 paused), run cycles since last step, run cycles since start.
  int m_state, m_pos, m_dir, m_el, m_rc;
  logic [N-1:0] m_led;
  logic m_step;
  logic smp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_region(input int p);
    if (p > LB) return 2;
    else if (p < RB) return 1;
    else return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = START; m_dir = 0; m_el = 0; m_rc = 0;
    m_led = '0; m_step = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] nl;
    int nst;
    bit ph;
    nl = '0;
    if (m_state == 1) begin
      if (m_pos > LB) ph = ((m_rc / HALF_L) % 2) == 0;
      else if (m_pos < RB) ph = ((m_rc / HALF_R) % 2) == 0;
      else ph = 1'b1;
      nl[m_pos] = ph;
    end else if (m_state == 2) begin
      nl[m_pos] = 1'b1;
    end
    m_step = 1'b0;
    if (m_state == 1 && !stop) begin
      m_rc++;
      if (m_el + 1 == CLK_PER_TICK * (m_dir ? T_UP : T_DOWN)) begin
        m_el = 0;
        m_step = 1'b1;
        if (m_dir != 0) begin
          if (m_pos == N - 1) begin m_pos = N - 2; m_dir = 0; end
          else m_pos++;
        end else begin
          if (m_pos == 0) begin m_pos = 1; m_dir = 1; end
          else m_pos--;
        end
      end else begin
        m_el++;
      end
    end
    nst = m_state;
    if (stop) nst = 0;
    else if (start && m_state == 0) begin
      nst = 1; m_pos = START; m_dir = 0; m_el = 0; m_rc = 0;
    end
    else if (pause && m_state == 1) nst = 2;
    else if (pause && m_state == 2) nst = 1;
    m_state = nst;
    m_led = nl;
  endtask

  task automatic check_all();
    chk("led", led, m_led);
    chk("pos", pos, m_pos);
    chk("dir", dir, m_dir);
    chk("region", region, exp_region(m_pos));
    chk("running", running, m_state == 1);
    chk("step", step, m_step);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  task automatic wait_step(input int maxc, output int n);
    int p;
    p = pos;
    smp.delete();
    n = 0;
    do begin
      cyc();
      n++;
      smp.push_back(led[p]);
    end while (step !== 1'b1 && n < maxc);
    if (step !== 1'b1) chk("step_timeout", 32'd0, 32'd1);
  endtask

  typedef struct { logic s; logic p; logic t; logic exp_run; } ctl_t;
  typedef struct { int cur; logic [1:0] rg; int half; int gap; int npos; int ndir; } seg_t;

  ctl_t ctl[11];
  seg_t seg[11];

  initial begin
    int n, viol, r;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;

    ctl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    ctl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    ctl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    ctl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    ctl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    ctl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    ctl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    ctl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    ctl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    ctl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    ctl[10] = '{1'b1, 1'b0, 1'b1, 1'b0};

    seg[0]  = '{2, 2'b00, 0,      20, 1, 0};
    seg[1]  = '{1, 2'b00, 0,      20, 0, 0};
    seg[2]  = '{0, 2'b01, HALF_R, 20, 1, 1};
    seg[3]  = '{1, 2'b00, 0,      40, 2, 1};
    seg[4]  = '{2, 2'b00, 0,      40, 3, 1};
    seg[5]  = '{3, 2'b00, 0,      40, 4, 1};
    seg[6]  = '{4, 2'b00, 0,      40, 5, 1};
    seg[7]  = '{5, 2'b00, 0,      40, 6, 1};
    seg[8]  = '{6, 2'b10, HALF_L, 40, 7, 1};
    seg[9]  = '{7, 2'b10, HALF_L, 40, 6, 0};
    seg[10] = '{6, 2'b10, HALF_L, 20, 5, 0};

    do_reset();
    chk("rst_led", led, 8'h00);
    chk("rst_pos", pos, 3'd3);
    chk("rst_running", running, 1'b0);

    // Control priority table, one pulse per vector.
    for (int i = 0; i < 11; i++) begin
      start = ctl[i].s; pause = ctl[i].p; stop = ctl[i].t;
      cyc();
      start = 1'b0; pause = 1'b0; stop = 1'b0;
      chk("ctl_running", running, ctl[i].exp_run);
      cyc();
    end

    // Start, first step, then a full bounce sweep.
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_running", running, 1'b1);
    chk("start_led0", led, 8'h00);
    cyc();
    chk("start_led1", led, 8'b0000_1000);
    wait_step(100, n);
    chk("first_gap", n + 1, 20);
    chk("first_pos", pos, 3'd2);
    chk("first_dir", dir, 1'b0);

    for (int i = 0; i < 11; i++) begin
      chk("seg_pos", pos, seg[i].cur);
      chk("seg_region", region, seg[i].rg);
      wait_step(200, n);
      chk("seg_gap", n, seg[i].gap);
      chk("seg_npos", pos, seg[i].npos);
      chk("seg_ndir", dir, seg[i].ndir);
      viol = 0;
      if (seg[i].half == 0) begin
        foreach (smp[k]) if (smp[k] !== 1'b1) viol++;
      end else begin
        for (int k = seg[i].half; k < smp.size(); k++)
          if (smp[k] === smp[k - seg[i].half]) viol++;
      end
      chk("seg_blink", viol, 0);
    end

    // Pause 7 clk after a step, hold 100 clk, resume.
    repeat (6) cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    viol = 0;
    repeat (100) begin
      cyc();
      if (led !== 8'b0010_0000 || step !== 1'b0 || running !== 1'b0) viol++;
    end
    chk("pause_hold", viol, 0);
    pause = 1'b1; cyc(); pause = 1'b0;
    wait_step(100, n);
    chk("resume_gap", n, 13);
    chk("resume_pos", pos, 3'd4);

    // start+stop together in RUN, then a lone pause in IDLE.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("ss_running", running, 1'b0);
    cyc();
    chk("ss_led", led, 8'h00);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("idle_pause_running", running, 1'b0);
    chk("idle_pause_pos", pos, 3'd4);

    // Asynchronous reset partway through a step count at pos 5.
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 12 && pos != 3'd5; k++) wait_step(100, n);
    chk("reach5", pos, 3'd5);
    repeat (7) cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_led", led, 8'h00);
    chk("arst_pos", pos, 3'd3);
    chk("arst_dir", dir, 1'b0);
    chk("arst_running", running, 1'b0);
    chk("arst_step", step, 1'b0);
    @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b0;

    // Random control pulses against the model.
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 999);
      start = (r < 20);
      pause = (r >= 20 && r < 40);
      stop  = (r >= 40 && r < 43);
      cyc();
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_bouncer.md
Name: led_bouncer

Overview:
- Parametrised successor of the board-level moving-indicator logic: a single lit LED ("EX") walks along an N_LED-wide bar and bounces at both ends.
- Step time depends on direction.
- LED blinks at a region-dependent rate near the left and right ends.
- Adds start/pause/stop control and status outputs (pos, dir, region, step) for the 7-segment and top-level FSMs to consume.

Parameters:
- N_LED, 16, LED bar width (>=4)
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 100, movement tick rate; CLK_HZ/TICK_HZ must be an integer >=2
- T_UP, 160, ticks per step while moving to higher index (>=1)
- T_DOWN, 50, ticks per step while moving to lower index (>=1)
- LB, 10, left boundary; pos > LB is the LEFT region
- RB, 2, right boundary; pos < RB is the RIGHT region (RB <= LB)
- START_POS, 7, position loaded on start (< N_LED)
- DIR_INIT, 0, direction loaded on start (1 = up)
- BLINK_L_HZ, 5, LEFT-region blink rate
- BLINK_R_HZ, 15, RIGHT-region blink rate

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; IDLE -> RUN
- pause  in  1  one-cycle pulse; toggles RUN <-> PAUSED
- stop  in  1  one-cycle pulse; any state -> IDLE
- led  out  N_LED  LED drive, one-hot or zero
- pos  out  $clog2(N_LED)  current EX position
- dir  out  1  current direction (1 = up)
- region  out  2  2'b10 LEFT, 2'b01 RIGHT, 2'b00 MIDDLE
- running  out  1  high in RUN
- step  out  1  one-cycle pulse on the cycle pos updates

Behaviour:
- Reset:
  - State IDLE, pos=START_POS, dir=DIR_INIT, led=0, running=0, step=0.
  - Prescaler, tick counter and blink counters = 0; blink phases = 1.
- States: IDLE, RUN, PAUSED (2-bit encoding).
- IDLE:
  - led=0; pos and dir held.
  - On start: next cycle state=RUN; pos=START_POS, dir=DIR_INIT; prescaler, tick counter, blink counters cleared; blink phases=1.
- RUN:
  - Prescaler counts 0..CLK_HZ/TICK_HZ-1 and emits an internal tick on the terminal count.
  - Tick counter increments on each tick.
  - On a tick with tick counter == (dir ? T_UP : T_DOWN)-1: the counter clears and pos/dir update at the next clock edge, with step high for that same cycle.
  - Update rules: dir=1 and pos<N_LED-1 -> pos+1. dir=1 and pos==N_LED-1 -> pos=N_LED-2, dir=0. dir=0 and pos>0 -> pos-1. dir=0 and pos==0 -> pos=1, dir=1.
  - A step never lands on an out-of-range index.
- PAUSED:
  - Prescaler, tick counter and blink counters frozen.
  - led shows pos solid regardless of region.
  - pause -> RUN, resuming the counts exactly where they froze.
- Control priority: stop > start > pause in the same cycle.
  - start in RUN/PAUSED is ignored.
  - pause in IDLE is ignored.
- Region decode: combinational from pos.
- led in RUN (registered, one-cycle latency from pos/phase):
  - MIDDLE: bit pos = 1.
  - LEFT: bit pos = phase_L.
  - RIGHT: bit pos = phase_R.
  - All other bits 0.
- Blinkers: free-running only in RUN. phase_x toggles every CLK_HZ/(2*BLINK_x_HZ) cycles (integer division; minimum 1).
- Width rules:
  - Prescaler width = $clog2(CLK_HZ/TICK_HZ).
  - Tick counter width = $clog2(max(T_UP,T_DOWN)+1).
  - No counter may wrap before its terminal compare.
- rst mid-operation: immediate return to reset values, with no step pulse.

Decomposition:
- Shared package led_bouncer_pkg:
  - state enum (ST_IDLE, ST_RUN, ST_PAUSED)
  - region codes (REG_MID, REG_RIGHT, REG_LEFT)
  - clog2-based width helper functions
- One sub-module, blink_gen: parameters CLK_HZ and RATE_HZ; ports clk, rst, en, clr, phase. Instantiated twice (LEFT and RIGHT).
- Prescaler, tick counter and FSM stay in led_bouncer.

Test Plan:
Bench parameters: N_LED=8, CLK_HZ=1000, TICK_HZ=100 (10 clk/tick), T_UP=4, T_DOWN=2, LB=5, RB=1, START_POS=3, DIR_INIT=0, BLINK_L_HZ=50 (toggle every 10 clk), BLINK_R_HZ=100 (toggle every 5 clk).
1. Reset then start -> led=8'b0000_1000 one cycle after RUN entry; first step after 20 clk, pos=2, dir=0, step pulse of exactly 1 cycle.
2. Run from pos 3 down -> pos 2,1,0 at 20-clk spacing; then pos=1, dir=1; then up steps spaced 40 clk; at pos 7 the next step gives pos=6, dir=0.
3. pos=0 (RIGHT) -> region=01; led[0] toggles every 5 clk. pos=6 (LEFT) -> region=10; led[6] toggles every 10 clk. pos=3 -> led[3] steady 1.
4. pause 7 clk after a step, hold 100 clk, pause again -> led solid during pause; next step occurs 13 clk after resume.
5. start and stop asserted in the same cycle while RUN -> IDLE, led=0, running=0; a lone pause in IDLE -> no change.
6. rst asserted mid-step-count at pos=5 -> outputs return to reset values asynchronously; no step pulse.
